// File: rtl/bounce_square_render_pkg.sv
// Shared types and constants for the bouncing-square renderer: motion FSM states,
// axis direction encoding, colour constants and the palette helper.
package bounce_square_render_pkg;

  localparam int CORDW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_X,
    ST_MOVE_Y,
    ST_RECOLOR
  } motion_state_e;

  // DIR_INC is right/down, DIR_DEC is left/up
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: 2'b00, g: 2'b00, b: 2'b00};
  localparam rgb_t BG_COLOR  = '{r: 2'b00, g: 2'b00, b: 2'b01};
  localparam rgb_t BG_ALT    = '{r: 2'b00, g: 2'b00, b: 2'b10};

  function automatic rgb_t palette(input logic [2:0] cidx);
    rgb_t c;
    c.r = {2{cidx[0]}};
    c.g = {2{cidx[1]}};
    c.b = {2{cidx[2]}};
    return c;
  endfunction

  // Colour index cycles 1..7 so the square is never black
  function automatic logic [2:0] next_cidx(input logic [2:0] cidx);
    return (cidx == 3'd7) ? 3'd1 : cidx + 3'd1;
  endfunction

endpackage

// File: rtl/bounce_square_render_if.sv
// Video bundle between the 480p timing generator and the renderer: timing in,
// re-aligned syncs and 2-bit RGB out.
interface bounce_square_render_if #(
  parameter int CORDW = bounce_square_render_pkg::CORDW_DEF
);
  logic signed [CORDW-1:0] sx;
  logic signed [CORDW-1:0] sy;
  logic                    de_in;
  logic                    frame;
  logic                    hsync_in;
  logic                    vsync_in;
  logic                    hsync_out;
  logic                    vsync_out;
  logic                    de_out;
  logic [1:0]              r;
  logic [1:0]              g;
  logic [1:0]              b;

  modport master (
    output sx, sy, de_in, frame, hsync_in, vsync_in,
    input  hsync_out, vsync_out, de_out, r, g, b
  );

  modport slave (
    input  sx, sy, de_in, frame, hsync_in, vsync_in,
    output hsync_out, vsync_out, de_out, r, g, b
  );
endinterface

// File: rtl/bounce_square_render_axis.sv
// bounce_axis: one axis of square motion; steps by SPEED when enabled and
// reverses at the active-area edges, flagging the bounce for that update.
module bounce_axis
  import bounce_square_render_pkg::*;
#(
  parameter int POSW   = 10,
  parameter int RES    = 640,
  parameter int Q_SIZE = 32,
  parameter int SPEED  = 2,
  parameter int START  = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [POSW-1:0] pos,
  output logic            bounce
);

  localparam logic [POSW-1:0] HI_LIM    = POSW'(RES - Q_SIZE - SPEED);
  localparam logic [POSW-1:0] HI_POS    = POSW'(RES - Q_SIZE);
  localparam logic [POSW-1:0] STEP      = POSW'(SPEED);
  localparam logic [POSW-1:0] START_POS = POSW'(START);

  logic [POSW-1:0] pos_q, pos_d;
  dir_e            dir_q, dir_d;

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    bounce = 1'b0;
    if (en) begin
      if (dir_q == DIR_INC) begin
        if (pos_q >= HI_LIM) begin
          pos_d  = HI_POS;
          dir_d  = DIR_DEC;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q + STEP;
        end
      end else begin
        if (pos_q <= STEP) begin
          pos_d  = '0;
          dir_d  = DIR_INC;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= START_POS;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/bounce_square_render.sv
// Renders a bouncing, colour-changing square behind a fixed 2-cycle pixel pipeline.
// Define CHECKER_BG_EN for a 16-pixel checkerboard background instead of a flat one.
module bounce_square_render
  import bounce_square_render_pkg::*;
#(
  parameter int CORDW     = CORDW_DEF,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int Q_SIZE    = 32,
  parameter int SPEED     = 2,
  parameter int FRAME_DIV = 1,
  parameter int START_X   = 100,
  parameter int START_Y   = 50
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix_n,
  bounce_square_render_if.slave  vid
);

  localparam int POSW = $clog2((H_RES > V_RES) ? H_RES : V_RES);
  localparam int DIVW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(FRAME_DIV - 1);
  localparam logic signed [CORDW-1:0] Q_SIZE_S = CORDW'(Q_SIZE);

  motion_state_e   state_q, state_d;
  logic [DIVW-1:0] divcnt_q, divcnt_d;
  logic            bflag_q, bflag_d;
  logic [2:0]      cidx_q, cidx_d;

  logic [POSW-1:0] qx, qy;
  logic            bounce_x, bounce_y;

  bounce_axis #(
    .POSW(POSW), .RES(H_RES), .Q_SIZE(Q_SIZE), .SPEED(SPEED), .START(START_X)
  ) u_axis_x (
    .clk(clk_pix), .rst_n(rst_pix_n), .en(state_q == ST_MOVE_X),
    .pos(qx), .bounce(bounce_x)
  );

  bounce_axis #(
    .POSW(POSW), .RES(V_RES), .Q_SIZE(Q_SIZE), .SPEED(SPEED), .START(START_Y)
  ) u_axis_y (
    .clk(clk_pix), .rst_n(rst_pix_n), .en(state_q == ST_MOVE_Y),
    .pos(qy), .bounce(bounce_y)
  );

  // Frame pulses arriving mid-update are dropped and do not advance the divider
  always_comb begin
    state_d  = state_q;
    divcnt_d = divcnt_q;
    bflag_d  = bflag_q;
    cidx_d   = cidx_q;
    case (state_q)
      ST_IDLE: begin
        if (vid.frame) begin
          if (divcnt_q == DIV_LAST) begin
            divcnt_d = '0;
            state_d  = ST_MOVE_X;
          end else begin
            divcnt_d = divcnt_q + DIVW'(1);
          end
        end
      end
      ST_MOVE_X: begin
        bflag_d = bflag_q | bounce_x;
        state_d = ST_MOVE_Y;
      end
      ST_MOVE_Y: begin
        bflag_d = bflag_q | bounce_y;
        state_d = ST_RECOLOR;
      end
      ST_RECOLOR: begin
        if (bflag_q) cidx_d = next_cidx(cidx_q);
        bflag_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q  <= ST_IDLE;
      divcnt_q <= '0;
      bflag_q  <= 1'b0;
      cidx_q   <= 3'd1;
    end else begin
      state_q  <= state_d;
      divcnt_q <= divcnt_d;
      bflag_q  <= bflag_d;
      cidx_q   <= cidx_d;
    end
  end

  logic signed [CORDW-1:0] qx_s, qy_s;
  logic in_sq1_d;
  assign qx_s = $signed({{(CORDW-POSW){1'b0}}, qx});
  assign qy_s = $signed({{(CORDW-POSW){1'b0}}, qy});
  assign in_sq1_d = (vid.sx >= qx_s) && (vid.sx < qx_s + Q_SIZE_S) &&
                    (vid.sy >= qy_s) && (vid.sy < qy_s + Q_SIZE_S);

  logic de1_q, hs1_q, vs1_q, in_sq1_q;
  logic de2_q, hs2_q, vs2_q;
  rgb_t rgb2_q, rgb2_d;
  rgb_t bg;

`ifdef CHECKER_BG_EN
  logic chk1_q;
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) chk1_q <= 1'b0;
    else            chk1_q <= vid.sx[4] ^ vid.sy[4];
  end
  assign bg = chk1_q ? BG_ALT : BG_COLOR;
`else
  assign bg = BG_COLOR;
`endif

  always_comb begin
    rgb2_d = bg;
    if (!de1_q)        rgb2_d = RGB_BLACK;
    else if (in_sq1_q) rgb2_d = palette(cidx_q);
  end

  // Syncs idle high so the monitor sees no pulses while held in reset
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de1_q    <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      in_sq1_q <= 1'b0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      rgb2_q   <= RGB_BLACK;
    end else begin
      de1_q    <= vid.de_in;
      hs1_q    <= vid.hsync_in;
      vs1_q    <= vid.vsync_in;
      in_sq1_q <= in_sq1_d;
      de2_q    <= de1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      rgb2_q   <= rgb2_d;
    end
  end

  assign vid.de_out    = de2_q;
  assign vid.hsync_out = hs2_q;
  assign vid.vsync_out = vs2_q;
  assign vid.r         = rgb2_q.r;
  assign vid.g         = rgb2_q.g;
  assign vid.b         = rgb2_q.b;

endmodule

// File: doc/bounce_square_render.md
Name: bounce_square_render

Overview:
- Pixel-rendering stage directly downstream of the 480p display timing generator.
- Consumes the generator's screen position and its sync/control strobes (sx, sy, de, frame, hsync, vsync).
- Draws a solid square that moves once per frame and bounces off the active-area edges; its colour changes on each bounce.
- Emits 2-bit-per-channel RGB with syncs re-aligned to the pixel pipeline, ready for the VGA output pins.

Parameters:
- CORDW, 16, signed coordinate width; must match the timing generator.
- H_RES, 640, active width in pixels.
- V_RES, 480, active height in lines.
- Q_SIZE, 32, square side length in pixels.
- SPEED, 2, pixels moved per axis per update.
- FRAME_DIV, 1, frame pulses per position update (≥1).
- START_X, 100, reset X position of the square's top-left corner.
- START_Y, 50, reset Y position of the square's top-left corner.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix_n  in  1  reset; asynchronous, active-low.
- sx  in  CORDW  signed horizontal position.
- sy  in  CORDW  signed vertical position.
- de_in  in  1  data enable.
- frame  in  1  single-cycle start-of-frame strobe (fires in blanking).
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hsync_out  out  1  hsync delayed 2 cycles.
- vsync_out  out  1  vsync delayed 2 cycles.
- de_out  out  1  de delayed 2 cycles.
- r  out  2  red.
- g  out  2  green.
- b  out  2  blue.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: hsync_out=1, vsync_out=1, de_out=0, r=g=b=0.
  - State: qx=START_X, qy=START_Y, dirx=right, diry=down, cidx=1, divcnt=0, FSM=IDLE.
- Pixel pipeline, fixed 2-cycle latency:
  - Stage 1 registers de/hsync/vsync and in_sq = (sx≥qx)&&(sx<qx+Q_SIZE)&&(sy≥qy)&&(sy<qy+Q_SIZE). All comparisons are signed CORDW.
  - Stage 2 registers syncs/de and RGB:
    - !de → RGB 0.
    - in_sq → r={2{cidx[0]}}, g={2{cidx[1]}}, b={2{cidx[2]}}.
    - Otherwise background r=0, g=0, b=2'b01.
- Motion FSM, states IDLE, MOVE_X, MOVE_Y, RECOLOR:
  - IDLE on frame=1:
    - If divcnt==FRAME_DIV-1: divcnt←0, go to MOVE_X.
    - Else: divcnt←divcnt+1, stay in IDLE.
  - MOVE_X, moving right:
    - If qx ≥ H_RES-Q_SIZE-SPEED: qx←H_RES-Q_SIZE, dirx←left, set bounce flag.
    - Else qx←qx+SPEED.
  - MOVE_X, moving left:
    - If qx ≤ SPEED: qx←0, dirx←right, set bounce flag.
    - Else qx←qx-SPEED.
  - MOVE_X → MOVE_Y.
  - MOVE_Y: same rules as MOVE_X using qy/diry/V_RES. MOVE_Y → RECOLOR.
  - RECOLOR:
    - If bounce flag set: cidx←(cidx==7)?1:cidx+1, applied once even when both axes bounced.
    - Clear bounce flag; go to IDLE.
  - frame asserted while FSM ≠ IDLE is ignored; divcnt does not change.
- Because updates complete within 4 cycles of the frame pulse (vertical blanking), the square never tears.
- cidx never equals 0.
- qx/qy are unsigned, log2(max(H_RES,V_RES)) bits. They are zero-extended to CORDW for comparison.
- Reset mid-frame: position, direction and colour return to reset values immediately. The output is valid again 2 cycles after release.

Optional Feature:
- Macro: CHECKER_BG_EN.
- Defined: background colour = (sx[4]^sy[4]) ? {r=0,g=0,b=2'b10} : {r=0,g=0,b=2'b01}, using stage-1-registered sx[4]/sy[4]. Latency is unchanged.
- Undefined: background is a flat r=0, g=0, b=2'b01. No extra registers.

Decomposition:
- Shared package holds:
  - Motion FSM state encoding.
  - Direction encoding (RIGHT/DOWN=0, LEFT/UP=1).
  - Background and palette colour constants.
  - CORDW default.
- One natural sub-module, bounce_axis: single-axis position/direction update with bounce-flag output. It is instantiated twice, for X and Y, and enabled by the FSM state.

Test Plan:
- Assert rst_pix_n=0 mid-line → de_out=0, RGB=0, hsync_out=vsync_out=1 immediately. In the first frame after release, pixel (100,50) is red (r=3,g=0,b=0) and (99,50) is background (b=1).
- de_in rises at sx=0; hsync_in falls at an arbitrary cycle → de_out and hsync_out follow exactly 2 cycles later.
- One frame pulse with defaults → square at (102,52): pixel (101,51) is background, (102,52) and (133,83) are red, (134,84) is background.
- START_X=607, other defaults → after the 1st frame qx=608, dirx=left, cidx=2 (green). After the 2nd frame qx=606 and cidx stays 2.
- START_X=607, START_Y=447 → both axes bounce in the same update: qx=608, qy=448, cidx=2 (not 3).
- FRAME_DIV=3, pulse frame 6 times → qx goes 100→102 on pulse 3 and →104 on pulse 6, unchanged otherwise. A frame pulse injected 2 cycles after a move begins is ignored.
